// File: rtl/slm_line_driver_if.sv
// slm_line_driver_if: FIFO read handshake and SLM beat bus of the line driver.
// master = line driver side, slave = controller / FIFO / SLM side.
interface slm_line_driver_if #(
  parameter int unsigned LINE_BITS = 10
) ();
  logic                 reset_per_frame;
  logic                 line_of_data_available;
  logic                 get_next_word;
  logic [31:0]          sc32_fifo_data_out;
  logic                 invert;
  logic [15:0]          slm_data;
  logic                 slm_data_valid;
  logic                 slm_line_start;
  logic                 line_done;
  logic                 frame_done;
  logic [LINE_BITS-1:0] line_index;

  modport master (
    input  reset_per_frame, line_of_data_available, sc32_fifo_data_out, invert,
    output get_next_word, slm_data, slm_data_valid, slm_line_start,
           line_done, frame_done, line_index
  );

  modport slave (
    output reset_per_frame, line_of_data_available, sc32_fifo_data_out, invert,
    input  get_next_word, slm_data, slm_data_valid, slm_line_start,
           line_done, frame_done, line_index
  );
endinterface

// File: rtl/slm_line_driver.sv
// slm_line_driver: pulls one display line of 32-bit words from the sc32 FIFO
// and streams it as contiguous 16-bit beats (low half first) on the SLM bus,
// tracking line/frame position.
// Optional feature macro: SLM_LINE_DRIVER_INVERT_EN (beats XORed with the
// invert flag latched at line start; when undefined `invert` is ignored).
module slm_line_driver #(
  parameter int unsigned WORDS_PER_LINE  = 40,
  parameter int unsigned LINES_PER_FRAME = 1024
) (
  input logic          fpga_clk,
  input logic          reset_all,
  slm_line_driver_if.master bus
);
  localparam int unsigned LINE_BITS = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam int unsigned WL_BITS   = 8;
  localparam int unsigned BEAT_W    = 16;
  localparam int unsigned WORD_W    = 32;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, BEAT_LO, BEAT_HI, LINE_END
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   word_q;
  logic [WL_BITS-1:0]  words_left;
  logic                rd_pend;
  logic [BEAT_W-1:0]   inv_mask_c;

`ifdef SLM_LINE_DRIVER_INVERT_EN
  logic inv_q;

  // Frame polarity, captured once per line so mid-line toggles are ignored.
  always_ff @(posedge fpga_clk or posedge reset_all) begin
    if (reset_all) begin
      inv_q <= 1'b0;
    end else if (bus.reset_per_frame) begin
      inv_q <= 1'b0;
    end else if (state == IDLE && bus.line_of_data_available) begin
      inv_q <= bus.invert;
    end
  end

  assign inv_mask_c = {BEAT_W{inv_q}};
`else
  logic unused_invert;
  assign unused_invert = bus.invert;
  assign inv_mask_c    = '0;
`endif

  // Line sequencer: FIFO reads every other cycle keep the beat stream gapless.
  always_ff @(posedge fpga_clk or posedge reset_all) begin
    if (reset_all) begin
      state               <= IDLE;
      word_q              <= '0;
      words_left          <= '0;
      rd_pend             <= 1'b0;
      bus.get_next_word   <= 1'b0;
      bus.slm_data        <= '0;
      bus.slm_data_valid  <= 1'b0;
      bus.slm_line_start  <= 1'b0;
      bus.line_done       <= 1'b0;
      bus.frame_done      <= 1'b0;
      bus.line_index      <= '0;
    end else begin
      bus.get_next_word  <= 1'b0;
      bus.slm_data_valid <= 1'b0;
      bus.slm_line_start <= 1'b0;
      bus.line_done      <= 1'b0;
      bus.frame_done     <= 1'b0;

      if (bus.reset_per_frame) begin
        state          <= IDLE;
        words_left     <= '0;
        rd_pend        <= 1'b0;
        bus.line_index <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.line_of_data_available) begin
              bus.get_next_word <= 1'b1;
              words_left        <= WL_BITS'(WORDS_PER_LINE - 1);
              state             <= FETCH;
            end
          end

          FETCH: state <= LOAD;

          LOAD: begin
            word_q             <= bus.sc32_fifo_data_out;
            bus.slm_data       <= bus.sc32_fifo_data_out[BEAT_W-1:0] ^ inv_mask_c;
            bus.slm_data_valid <= 1'b1;
            bus.slm_line_start <= 1'b1;
            if (words_left != '0) begin
              bus.get_next_word <= 1'b1;
              words_left        <= words_left - WL_BITS'(1);
              rd_pend           <= 1'b1;
            end else begin
              rd_pend <= 1'b0;
            end
            state <= BEAT_LO;
          end

          BEAT_LO: begin
            bus.slm_data       <= word_q[WORD_W-1:BEAT_W] ^ inv_mask_c;
            bus.slm_data_valid <= 1'b1;
            state              <= BEAT_HI;
          end

          BEAT_HI: begin
            if (rd_pend) begin
              word_q             <= bus.sc32_fifo_data_out;
              bus.slm_data       <= bus.sc32_fifo_data_out[BEAT_W-1:0] ^ inv_mask_c;
              bus.slm_data_valid <= 1'b1;
              if (words_left != '0) begin
                bus.get_next_word <= 1'b1;
                words_left        <= words_left - WL_BITS'(1);
                rd_pend           <= 1'b1;
              end else begin
                rd_pend <= 1'b0;
              end
              state <= BEAT_LO;
            end else begin
              bus.line_done <= 1'b1;
              if (bus.line_index == LINE_BITS'(LINES_PER_FRAME - 1)) begin
                bus.frame_done <= 1'b1;
                bus.line_index <= '0;
              end else begin
                bus.line_index <= bus.line_index + LINE_BITS'(1);
              end
              state <= LINE_END;
            end
          end

          LINE_END: state <= IDLE;

          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
